digit_serial_adder: RTL and testbench
=====================================

# digit_serial_adder

- Parametrised multi-cycle adder for the arithmetic library; the next generation of the single-bit full-adder cell.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, least-significant digit first, through one DIGIT-bit adder slice.
- Uses a start/busy/done handshake and registers sum, carry-out and signed overflow.
- Sits between a requester (sequencer or datapath controller) and result consumers; area scales with DIGIT, not WIDTH.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits added per cycle; 1 <= DIGIT <= WIDTH; N = WIDTH/DIGIT cycles per operation.
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request; accepted only when busy=0.
- a  input  WIDTH  operand A, sampled on the accepting edge only.
- b  input  WIDTH  operand B, sampled on the accepting edge only.
- c  input  1  carry-in, sampled on the accepting edge only.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: sum/carry/overflow just updated.
- sum  output  WIDTH  result, held until next completion.
- carry  output  1  carry out of bit WIDTH-1.
- overflow  output  1  two's-complement signed overflow of the result.

## Operation
- FSM states: IDLE, RUN.
  - IDLE & start: capture a, b, c into operand/carry registers; clear digit counter; go RUN.
  - RUN: each edge adds digit i of A and B plus running carry, writes digit i of the internal result, updates running carry, increments counter.
  - RUN & last digit (counter = N-1): write all outputs, pulse done, go IDLE.
- start while busy=1 is ignored; no queuing, no error flag.
- Outputs update only on completion; operand changes after capture have no effect.
- Arithmetic: {carry, sum} = a + b_eff + c_eff, modulo 2^(WIDTH+1).
- overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]).
- In add mode, b_eff = b and c_eff = c.
- DIGIT = WIDTH is legal: N = 1, single-slice operation.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, sum=0, carry=0, overflow=0, internal registers 0.
- Reset mid-operation aborts immediately: no done pulse; outputs read 0.
- start accepted at edge k: busy=1 after edge k.
- Digits processed at edges k+1 .. k+N.
- After edge k+N: busy=0, done=1 for exactly one cycle, results valid.
- Latency: N cycles from accepting edge to done.
- Back-to-back: start high in the done cycle is accepted at edge k+N+1, since busy=0 then; throughput one operation per N+1 cycles.
- done and busy are never high together.

## Configuration
- DSA_SUB_EN defined: adds port sub (input, 1, sampled with the operands).
  - sub=1: b_eff = ~b, c_eff = 1, c ignored; computes a - b.
  - carry=1 means no borrow; overflow is signed subtraction overflow.
  - sub=0: add mode as above.
- DSA_SUB_EN undefined: no sub port; add only, b_eff = b, c_eff = c.

## Test plan
- Reset: hold rst_n=0 -> sum=0x0000, carry=0, overflow=0, busy=0, done=0. Release and idle 5 cycles -> no done.
- WIDTH=16, DIGIT=4, a=0x1234, b=0x4321, c=0 -> busy for 4 cycles, then done pulse with sum=0x5555, carry=0, overflow=0.
- Full carry ripple: a=0xFFFF, b=0x0000, c=1 -> sum=0x0000, carry=1, overflow=0. Then a=0x7FFF, b=0x0001, c=0 -> sum=0x8000, carry=0, overflow=1.
- Handshake: start pulsed again mid-operation with a=0x1111, b=0x1111 -> ignored; first result unchanged. start held in done cycle -> second operation accepted next edge, done 5 cycles after first done.
- Abort: rst_n=0 two cycles after start -> busy=0, done never pulses, outputs 0. Next start after release completes normally.
- DSA_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, carry=0, overflow=0. a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, carry=1, overflow=1.

Source files
------------

// File: rtl/digit_serial_adder.sv
// -----------------------------------------------------------------------------
// digit_serial_adder
//
// Multi-cycle adder that adds two WIDTH-bit operands plus a carry-in, DIGIT
// bits per clock, least-significant digit first. It uses a single DIGIT-bit
// adder slice, so area scales with DIGIT rather than WIDTH.
// An operation takes N = WIDTH/DIGIT cycles from the accepting edge to done.
//
// Optional feature: define DSA_SUB_EN to add the 'sub' input. When sub=1 the
// block computes a - b as a + ~b + 1, and c is ignored.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous, active-low reset
//   start     in   1      request; accepted only while busy=0
//   a, b      in   WIDTH  operands, sampled on the accepting edge only
//   c         in   1      carry-in, sampled on the accepting edge only
//   sub       in   1      (DSA_SUB_EN only) subtract select, sampled with a/b
//   busy      out  1      operation in progress
//   done      out  1      one-cycle pulse: sum/carry/overflow just updated
//   sum       out  WIDTH  result, held until the next completion
//   carry     out  1      carry out of bit WIDTH-1 (no-borrow when subtracting)
//   overflow  out  1      two's-complement signed overflow of the result
// -----------------------------------------------------------------------------
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
`ifdef DSA_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg, res_next;
    logic             carry_run_reg;
    logic             a_msb_reg, b_msb_reg;
    logic [CW-1:0]    cnt_reg;

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [DIGIT:0]   slice_full;
    logic             last_digit;

    // Operand conditioning applied once at capture time, so the serial
    // datapath only ever adds.
`ifdef DSA_SUB_EN
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub ? 1'b1 : c;
`else
    assign b_eff = b;
    assign c_eff = c;
`endif

    // Operand registers shift right each cycle, so the active digit is always
    // in the low DIGIT bits.
    assign slice_full = {1'b0, a_reg[DIGIT-1:0]}
                      + {1'b0, b_reg[DIGIT-1:0]}
                      + {{DIGIT{1'b0}}, carry_run_reg};

    assign last_digit = (cnt_reg == LAST);
    assign busy       = (state_reg == RUN);

    // The result register fills from the top: after N shifts, the first digit
    // computed has reached the least-significant position.
    always_comb begin
        res_next = res_reg >> DIGIT;
        res_next[WIDTH-1 -: DIGIT] = slice_full[DIGIT-1:0];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)      state_next = RUN;
            RUN:     if (last_digit) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg         <= '0;
            b_reg         <= '0;
            res_reg       <= '0;
            carry_run_reg <= 1'b0;
            a_msb_reg     <= 1'b0;
            b_msb_reg     <= 1'b0;
            cnt_reg       <= '0;
            done          <= 1'b0;
            sum           <= '0;
            carry         <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg         <= a;
                        b_reg         <= b_eff;
                        carry_run_reg <= c_eff;
                        // Sign bits are kept aside because the operand
                        // registers are shifted away during the run.
                        a_msb_reg     <= a[WIDTH-1];
                        b_msb_reg     <= b_eff[WIDTH-1];
                        res_reg       <= '0;
                        cnt_reg       <= '0;
                    end
                end
                RUN: begin
                    a_reg         <= a_reg >> DIGIT;
                    b_reg         <= b_reg >> DIGIT;
                    carry_run_reg <= slice_full[DIGIT];
                    res_reg       <= res_next;
                    cnt_reg       <= cnt_reg + 1'b1;
                    if (last_digit) begin
                        sum      <= res_next;
                        carry    <= slice_full[DIGIT];
                        overflow <= (a_msb_reg == b_msb_reg) &&
                                    (res_next[WIDTH-1] != a_msb_reg);
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_digit_serial_adder
//
// Self-checking bench for digit_serial_adder (WIDTH=16, DIGIT=4).
// Table-driven directed vectors, hand-written handshake/abort sequences and
// randomized operations checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_digit_serial_adder;

    localparam int W = 16;
    localparam int D = 4;
    localparam int N = W / D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c = 1'b0;
    logic         sub = 1'b0;
    logic         busy, done, carry, overflow;
    logic [W-1:0] sum;

    digit_serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .c        (c),
`ifdef DSA_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carry    (carry),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int acc_cyc = 0;

    typedef struct {
        string        name;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vc;
        logic         vs;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic mc, input logic ms,
                         output logic [W-1:0] es, output logic ec, output logic eo);
        int unsigned u;
        int sa, sb, sr;
        sa = $signed(ma);
        sb = $signed(mb);
        if (ms) begin
            u  = (int'(ma) - int'(mb)) & 32'hFFFF;
            es = u[W-1:0];
            ec = (ma >= mb);
            sr = sa - sb;
        end else begin
            u  = int'(ma) + int'(mb) + int'(mc);
            es = u[W-1:0];
            ec = u[W];
            sr = sa + sb + int'(mc);
        end
        eo = (sr > 32767) || (sr < -32768);
    endtask

    // Drive a request and let it be accepted; operands are scrambled afterwards
    // so that any late sampling would corrupt the result.
    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic ts, input string name);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_v; c = tc; sub = ts;
        @(posedge clk); #1;
        acc_cyc = cyc;
        chk({name, ".busy_after_accept"}, {31'b0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); c = 1'($urandom);
    endtask

    task automatic wait_done(input string name, output int lat);
        int i;
        i = 0;
        do begin
            @(posedge clk); #1;
            i++;
            if (busy && done) chk({name, ".busy_done_excl"}, 32'd1, 32'd0);
        end while (!done && i < 4 * N + 4);
        lat = cyc - acc_cyc;
        if (!done) chk({name, ".done_timeout"}, 32'd0, 32'd1);
        chk({name, ".busy_at_done"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic check_res(input string name, input logic [W-1:0] es,
                             input logic ec, input logic eo, input int lat,
                             input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                             input logic tc, input logic ts);
        chk({name, ".latency"},  lat, N);
        chk({name, ".sum"},      {16'b0, sum}, {16'b0, es});
        chk({name, ".carry"},    {31'b0, carry}, {31'b0, ec});
        chk({name, ".overflow"}, {31'b0, overflow}, {31'b0, eo});
        $display("op %-12s a=%h b=%h c=%b sub=%b -> sum=%h carry=%b ovf=%b lat=%0d (exp %h %b %b)",
                 name, ta, tb_v, tc, ts, sum, carry, overflow, lat, es, ec, eo);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic ts, input string name,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        int lat;
        launch(ta, tb_v, tc, ts, name);
        wait_done(name, lat);
        check_res(name, es, ec, eo, lat, ta, tb_v, tc, ts);
        @(posedge clk); #1;
        chk({name, ".done_one_cycle"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] es, ra, rb;
        logic         ec, eo, rc, rs;
        int           lat, done_seen;

        vecs.push_back('{"add_5555", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0});
        vecs.push_back('{"ripple",   16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{"pos_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
        vecs.push_back('{"neg_ovf",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
        vecs.push_back('{"max_cin",  16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
`ifdef DSA_SUB_EN
        vecs.push_back('{"sub_neg",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
        vecs.push_back('{"sub_ovf",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1});
`endif

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.sum",      {16'b0, sum}, 32'd0);
        chk("reset.carry",    {31'b0, carry}, 32'd0);
        chk("reset.overflow", {31'b0, overflow}, 32'd0);
        chk("reset.busy",     {31'b0, busy}, 32'd0);
        chk("reset.done",     {31'b0, done}, 32'd0);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        chk("idle.no_activity", done_seen, 0);

        // Directed table
        foreach (vecs[i])
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].vs, vecs[i].name,
                   vecs[i].es, vecs[i].ec, vecs[i].eo);

        // start pulsed while busy must be ignored
        launch(16'h1234, 16'h4321, 1'b0, 1'b0, "ignore");
        @(negedge clk);
        start = 1'b1; a = 16'h1111; b = 16'h1111;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", lat);
        check_res("ignore", 16'h5555, 1'b0, 1'b0, lat, 16'h1234, 16'h4321, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("ignore.no_second_op", {31'b0, busy | done}, 32'd0);

        // Back-to-back: start held in the done cycle
        launch(16'h0101, 16'h0202, 1'b0, 1'b0, "b2b_first");
        wait_done("b2b_first", lat);
        check_res("b2b_first", 16'h0303, 1'b0, 1'b0, lat, 16'h0101, 16'h0202, 1'b0, 1'b0);
        start = 1'b1; a = 16'hABCD; b = 16'h1111; c = 1'b1; sub = 1'b0;
        @(posedge clk); #1;
        acc_cyc = cyc;
        start = 1'b0; a = 16'h0; b = 16'h0; c = 1'b0;
        chk("b2b.accepted_busy", {31'b0, busy}, 32'd1);
        chk("b2b.done_cleared",  {31'b0, done}, 32'd0);
        wait_done("b2b_second", lat);
        check_res("b2b_second", 16'hBCDF, 1'b0, 1'b0, lat, 16'hABCD, 16'h1111, 1'b1, 1'b0);

        // Abort mid-operation with reset
        launch(16'h00FF, 16'h0001, 1'b0, 1'b0, "abort");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort.busy",     {31'b0, busy}, 32'd0);
        chk("abort.done",     {31'b0, done}, 32'd0);
        chk("abort.sum",      {16'b0, sum}, 32'd0);
        chk("abort.carry",    {31'b0, carry}, 32'd0);
        chk("abort.overflow", {31'b0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        chk("abort.no_done", done_seen, 0);
        run_op(16'h2222, 16'h3333, 1'b0, 1'b0, "post_abort", 16'h5555, 1'b0, 1'b0);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
`ifdef DSA_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            model(ra, rb, rc, rs, es, ec, eo);
            run_op(ra, rb, rc, rs, $sformatf("rand%0d", i), es, ec, eo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
